i2c_cmd_sequencer: RTL and testbench
====================================

Name: i2c_cmd_sequencer

Overview:
- Upstream command front-end for the I2C master top (newd/op/addr/din in; dout/busy/ack_err/done out).
- Buffers write and read commands from a valid/ready producer and issues them one at a time with the master's newd pulse protocol.
- Waits for completion and returns one response per command (data, ack_err) through a valid/ready response FIFO.
- Lets software or test logic queue bursts without hand-timing newd against done.

Parameters:
- CMD_DEPTH, 4: command FIFO entries; power of two, at least 2.
- RSP_DEPTH, 4: response FIFO entries; power of two, at least 2.
- NEWD_HOLD, 5: cycles i2c_newd is held high per issue; at least 1.
- TIMEOUT_CYCLES, 100000: watchdog limit in WAIT_DONE. Used only when I2C_SEQ_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command FIFO not full
- cmd_op  in  1  0 = write, 1 = read
- cmd_addr  in  7  7-bit slave address
- cmd_data  in  8  write data; ignored for reads
- rsp_valid  out  1  response FIFO not empty
- rsp_ready  in  1  consumer accepts response
- rsp_op  out  1  op of the completed command
- rsp_addr  out  7  address of the completed command
- rsp_data  out  8  read: captured i2c_dout; write: echoed cmd_data
- rsp_ack_err  out  1  master reported NACK, or timeout
- rsp_timeout  out  1  watchdog expired; constant 0 without the macro
- i2c_newd  out  1  to master newd
- i2c_op  out  1  to master op
- i2c_addr  out  7  to master addr
- i2c_din  out  8  to master din
- i2c_dout  in  8  from master dout
- i2c_busy  in  1  from master busy
- i2c_ack_err  in  1  from master ack_err
- i2c_done  in  1  from master done
- cmd_count  out  $clog2(CMD_DEPTH+1)  commands queued, excluding the one in flight
- idle  out  1  state IDLE, command FIFO empty, nothing in flight

Behaviour:
- Reset (async, rst=1):
  - Both FIFOs flushed; FSM forced to IDLE.
  - All outputs 0 except idle=1; cmd_ready=1 is allowed one cycle after reset release.
  - i2c_newd drops immediately. A master transaction already running is abandoned; no response is produced for it.
- Command FIFO:
  - Push on cmd_valid & cmd_ready; cmd_ready = !full, registered.
  - Simultaneous push and pop when full is not accepted: ready is low, so there is no bypass.
  - Push to a full FIFO cannot happen. Pop from an empty FIFO is never issued.
- Response FIFO:
  - Pop on rsp_valid & rsp_ready; rsp_* are driven from the head entry and are stable while rsp_valid=1 && !rsp_ready.
  - The FSM starts a command only if the response FIFO has at least one free slot counting the in-flight command, so a response is never dropped.
- done edge detect: done_q <= i2c_done; done_rise = i2c_done & ~done_q. Only done_rise is used, never the done level.
- FSM states: IDLE, ISSUE, WAIT_DONE, RESP.
  - IDLE → ISSUE when the command FIFO is non-empty, the response FIFO has a slot, and i2c_busy=0. On this transition the head is popped into the in-flight register and i2c_op/addr/din are loaded.
  - ISSUE: i2c_newd=1 for exactly NEWD_HOLD cycles via hold_cnt, then → WAIT_DONE with newd=0. If done_rise occurs during ISSUE: newd drops and the FSM goes → RESP.
  - WAIT_DONE: i2c_op/addr/din are held stable. On done_rise, capture i2c_dout (reads) and i2c_ack_err, then → RESP.
  - RESP: push one response entry, then → IDLE. Issue latency is at least 1 cycle after push; back-to-back commands have at least 2 idle cycles between newd pulses.
- ack_err: reported per command. The sequencer never retries and never flushes on error; the next command proceeds.
- Writes: rsp_data = cmd_data. Reads: rsp_data = i2c_dout sampled in the cycle done_rise is seen.

Optional Feature:
- I2C_SEQ_TIMEOUT_EN defined:
  - A 32-bit watchdog counts cycles in ISSUE and WAIT_DONE.
  - When it reaches TIMEOUT_CYCLES → RESP with rsp_timeout=1, rsp_ack_err=1, rsp_data=0.
  - IDLE still waits for i2c_busy=0 before the next issue.
- Undefined: no counter; rsp_timeout tied 0; WAIT_DONE waits indefinitely.

Decomposition:
- Package i2c_seq_pkg:
  - state enum {IDLE, ISSUE, WAIT_DONE, RESP}
  - cmd_t struct {op, addr[6:0], data[7:0]}
  - rsp_t struct {op, addr, data, ack_err, timeout}
  - constants OP_WR=1'b0, OP_RD=1'b1
- One sub-module, i2c_sync_fifo: parameterized WIDTH/DEPTH, async active-high rst, full/empty/count outputs. Instantiated twice, once for cmd_t and once for rsp_t.

Test Plan:
- Bench uses a behavioural master model with done rising 200 cycles after newd.
- Single write: cmd (op=0, addr=3, data=5) → i2c_newd high exactly 5 cycles with addr=3, din=5; one response (op=0, addr=3, data=5, ack_err=0).
- Single read: cmd (op=1, addr=2); model returns dout=0xA7 → response data=0xA7, ack_err=0.
- Burst: 6 commands pushed back-to-back with rsp_ready=0 → cmd_ready drops after 4 accepted. Only 4 newd pulses occur until rsp_ready=1, then the remaining 2 issue. Responses come out in order.
- NACK: model sets ack_err=1 on addr=4 → that response has ack_err=1; the following command to addr=1 completes normally.
- Reset mid-WAIT_DONE: rst asserted → i2c_newd=0, rsp_valid=0, idle=1 in the same cycle. No response appears after release.
- Timeout (macro on, TIMEOUT_CYCLES=50): model never raises done → response with rsp_timeout=1, rsp_ack_err=1, rsp_data=0 at cycle 50 after the issue started.

Source files
------------

// File: rtl/i2c_seq_pkg.sv
// Shared types for the I2C command sequencer: FSM states, command and
// response entries, and operation encodings.
package i2c_seq_pkg;

  // Sequencer FSM states
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    RESP      = 2'd3
  } state_t;

  // Operation encodings carried in cmd_op / rsp_op
  localparam logic OP_WR = 1'b0;
  localparam logic OP_RD = 1'b1;

  // One queued command as accepted from the producer
  typedef struct packed {
    logic       op;
    logic [6:0] addr;
    logic [7:0] data;
  } cmd_t;

  // One completed command as returned to the consumer
  typedef struct packed {
    logic       op;
    logic [6:0] addr;
    logic [7:0] data;
    logic       ack_err;
    logic       timeout;
  } rsp_t;

  localparam int CMD_W = $bits(cmd_t);
  localparam int RSP_W = $bits(rsp_t);

endpackage

// File: rtl/i2c_sync_fifo.sv
// Small first-word-fall-through FIFO used for both the command and the
// response queues. The head entry is always visible on dout; in_ready is a
// registered not-full flag that stays low while reset is asserted.
module i2c_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       in_ready,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic             in_ready_reg;
  logic             do_push;
  logic             do_pop;

  // A push is only honoured while ready, a pop only while data is present
  assign do_push = push & in_ready_reg;
  assign do_pop  = pop & (count_reg != '0);

  // Occupancy after this cycle's push/pop
  always_comb begin
    count_next = count_reg;
    case ({do_push, do_pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // Storage array; left unreset so it maps onto plain memory
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  // Pointers, occupancy and the registered ready flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      in_ready_reg <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      count_reg    <= count_next;
      in_ready_reg <= (count_next != CNT_W'(DEPTH));
    end
  end

  assign dout     = mem[rd_ptr_reg];
  assign in_ready = in_ready_reg;
  assign full     = (count_reg == CNT_W'(DEPTH));
  assign empty    = (count_reg == '0);
  assign count    = count_reg;

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// Command front-end for the I2C master: queues write/read commands, issues
// them one at a time with a fixed-width newd pulse, waits for the master's
// done edge and returns one response per command through a response queue.
// Optional watchdog: define I2C_SEQ_TIMEOUT_EN to abort a command that has
// not completed TIMEOUT_CYCLES cycles after it was issued.
module i2c_cmd_sequencer
  import i2c_seq_pkg::*;
#(
  parameter int CMD_DEPTH      = 4,
  parameter int RSP_DEPTH      = 4,
  parameter int NEWD_HOLD      = 5,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic                           cmd_op,
  input  logic [6:0]                     cmd_addr,
  input  logic [7:0]                     cmd_data,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic                           rsp_op,
  output logic [6:0]                     rsp_addr,
  output logic [7:0]                     rsp_data,
  output logic                           rsp_ack_err,
  output logic                           rsp_timeout,
  output logic                           i2c_newd,
  output logic                           i2c_op,
  output logic [6:0]                     i2c_addr,
  output logic [7:0]                     i2c_din,
  input  logic [7:0]                     i2c_dout,
  input  logic                           i2c_busy,
  input  logic                           i2c_ack_err,
  input  logic                           i2c_done,
  output logic [$clog2(CMD_DEPTH+1)-1:0] cmd_count,
  output logic                           idle
);

  localparam int HOLD_W = (NEWD_HOLD > 1) ? $clog2(NEWD_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(NEWD_HOLD - 1);

  state_t              state_reg;
  cmd_t                inflight_reg;
  logic                newd_reg;
  logic [HOLD_W-1:0]   hold_cnt_reg;
  logic [7:0]          rsp_data_reg;
  logic                rsp_ack_err_reg;
  logic                rsp_timeout_reg;
  logic                done_q_reg;
  logic                done_rise;
  logic                timeout_hit;

  cmd_t                cmd_in;
  cmd_t                cmd_head;
  logic                cmd_push;
  logic                cmd_pop;
  logic                cmd_empty;
  logic                unused_cmd_full;

  rsp_t                rsp_in;
  rsp_t                rsp_head;
  rsp_t                rsp_view;
  logic                rsp_push;
  logic                rsp_pop;
  logic                rsp_empty;
  logic                rsp_full;
  logic                unused_rsp_in_ready;
  logic [$clog2(RSP_DEPTH+1)-1:0] unused_rsp_count;

  // ---------------------------------------------------------------------
  // Command queue
  // ---------------------------------------------------------------------
  assign cmd_in   = {cmd_op, cmd_addr, cmd_data};
  assign cmd_push = cmd_valid & cmd_ready;

  // Start a command only when the master is free and its response is
  // guaranteed a slot; nothing is in flight while the FSM sits in IDLE.
  assign cmd_pop = (state_reg == IDLE) & ~cmd_empty & ~rsp_full & ~i2c_busy;

  i2c_sync_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (cmd_push),
    .din      (cmd_in),
    .pop      (cmd_pop),
    .dout     (cmd_head),
    .in_ready (cmd_ready),
    .full     (unused_cmd_full),
    .empty    (cmd_empty),
    .count    (cmd_count)
  );

  // ---------------------------------------------------------------------
  // Response queue
  // ---------------------------------------------------------------------
  assign rsp_push = (state_reg == RESP);
  assign rsp_in   = {inflight_reg.op, inflight_reg.addr, rsp_data_reg,
                     rsp_ack_err_reg, rsp_timeout_reg};
  assign rsp_pop  = rsp_valid & rsp_ready;

  i2c_sync_fifo #(
    .WIDTH (RSP_W),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (rsp_push),
    .din      (rsp_in),
    .pop      (rsp_pop),
    .dout     (rsp_head),
    .in_ready (unused_rsp_in_ready),
    .full     (rsp_full),
    .empty    (rsp_empty),
    .count    (unused_rsp_count)
  );

  // Outputs read zero while the queue is empty so stale storage never leaks
  assign rsp_valid   = ~rsp_empty;
  assign rsp_view    = rsp_empty ? '0 : rsp_head;
  assign rsp_op      = rsp_view.op;
  assign rsp_addr    = rsp_view.addr;
  assign rsp_data    = rsp_view.data;
  assign rsp_ack_err = rsp_view.ack_err;
  assign rsp_timeout = rsp_view.timeout;

  // ---------------------------------------------------------------------
  // Master completion edge
  // ---------------------------------------------------------------------
  // Delayed copy of done so that only its rising edge ends a command
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q_reg <= 1'b0;
    end else begin
      done_q_reg <= i2c_done;
    end
  end

  assign done_rise = i2c_done & ~done_q_reg;

  // ---------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------
`ifdef I2C_SEQ_TIMEOUT_EN
  logic [31:0] wdog_reg;
  logic        in_flight;

  assign in_flight = (state_reg == ISSUE) | (state_reg == WAIT_DONE);

  // Counts cycles since the command left IDLE; cleared whenever not in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_reg <= '0;
    end else if (in_flight) begin
      wdog_reg <= wdog_reg + 32'd1;
    end else begin
      wdog_reg <= '0;
    end
  end

  assign timeout_hit = in_flight & (wdog_reg == 32'(TIMEOUT_CYCLES - 1));
`else
  logic [31:0] unused_timeout_cfg;

  assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
  assign timeout_hit        = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Issue / wait / respond FSM with registered master-side outputs
  // ---------------------------------------------------------------------
  // One command at a time: pulse newd, wait for done (or watchdog), queue the response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      inflight_reg    <= '0;
      newd_reg        <= 1'b0;
      hold_cnt_reg    <= '0;
      rsp_data_reg    <= '0;
      rsp_ack_err_reg <= 1'b0;
      rsp_timeout_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (cmd_pop) begin
            inflight_reg    <= cmd_head;
            newd_reg        <= 1'b1;
            hold_cnt_reg    <= '0;
            // Writes echo their own data; reads overwrite this on completion
            rsp_data_reg    <= (cmd_head.op == OP_RD) ? 8'h00 : cmd_head.data;
            rsp_ack_err_reg <= 1'b0;
            rsp_timeout_reg <= 1'b0;
            state_reg       <= ISSUE;
          end
        end

        ISSUE: begin
          if (done_rise) begin
            // Master finished before the pulse ended: cut newd short
            newd_reg        <= 1'b0;
            rsp_ack_err_reg <= i2c_ack_err;
            if (inflight_reg.op == OP_RD) begin
              rsp_data_reg <= i2c_dout;
            end
            state_reg <= RESP;
          end else if (timeout_hit) begin
            newd_reg        <= 1'b0;
            rsp_data_reg    <= 8'h00;
            rsp_ack_err_reg <= 1'b1;
            rsp_timeout_reg <= 1'b1;
            state_reg       <= RESP;
          end else if (hold_cnt_reg == HOLD_LAST) begin
            newd_reg  <= 1'b0;
            state_reg <= WAIT_DONE;
          end else begin
            hold_cnt_reg <= hold_cnt_reg + 1'b1;
          end
        end

        WAIT_DONE: begin
          if (done_rise) begin
            rsp_ack_err_reg <= i2c_ack_err;
            if (inflight_reg.op == OP_RD) begin
              rsp_data_reg <= i2c_dout;
            end
            state_reg <= RESP;
          end else if (timeout_hit) begin
            rsp_data_reg    <= 8'h00;
            rsp_ack_err_reg <= 1'b1;
            rsp_timeout_reg <= 1'b1;
            state_reg       <= RESP;
          end
        end

        RESP: begin
          // The response entry is pushed during this state
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
          newd_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign i2c_newd = newd_reg;
  assign i2c_op   = inflight_reg.op;
  assign i2c_addr = inflight_reg.addr;
  assign i2c_din  = inflight_reg.data;

  assign idle = (state_reg == IDLE) & cmd_empty;

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Directed bench for i2c_cmd_sequencer with a behavioural I2C master model
// (done rises 200 cycles after newd) and a response scoreboard.
// Define I2C_SEQ_TIMEOUT_EN to also exercise the watchdog path.
module tb_i2c_cmd_sequencer;
  import i2c_seq_pkg::*;

  localparam int CMD_DEPTH = 4;
  localparam int RSP_DEPTH = 4;
  localparam int NEWD_HOLD = 5;
  localparam int TO_CYCLES = 50;
  localparam int MODEL_LAT = 200;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_op = 1'b0;
  logic [6:0] cmd_addr = '0;
  logic [7:0] cmd_data = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic       rsp_op;
  logic [6:0] rsp_addr;
  logic [7:0] rsp_data;
  logic       rsp_ack_err;
  logic       rsp_timeout;
  logic       i2c_newd;
  logic       i2c_op;
  logic [6:0] i2c_addr;
  logic [7:0] i2c_din;
  logic [7:0] i2c_dout = '0;
  logic       i2c_busy;
  logic       i2c_ack_err = 1'b0;
  logic       i2c_done;
  logic [$clog2(CMD_DEPTH+1)-1:0] cmd_count;
  logic       idle;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulses = 0;
  int rsp_seen = 0;
  int newd_rise_cyc = 0;

  cmd_t iss_q[$];
  rsp_t exp_q[$];

  i2c_cmd_sequencer #(
    .CMD_DEPTH      (CMD_DEPTH),
    .RSP_DEPTH      (RSP_DEPTH),
    .NEWD_HOLD      (NEWD_HOLD),
    .TIMEOUT_CYCLES (TO_CYCLES)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_addr    (cmd_addr),
    .cmd_data    (cmd_data),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_op      (rsp_op),
    .rsp_addr    (rsp_addr),
    .rsp_data    (rsp_data),
    .rsp_ack_err (rsp_ack_err),
    .rsp_timeout (rsp_timeout),
    .i2c_newd    (i2c_newd),
    .i2c_op      (i2c_op),
    .i2c_addr    (i2c_addr),
    .i2c_din     (i2c_din),
    .i2c_dout    (i2c_dout),
    .i2c_busy    (i2c_busy),
    .i2c_ack_err (i2c_ack_err),
    .i2c_done    (i2c_done),
    .cmd_count   (cmd_count),
    .idle        (idle)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_dout(input logic [6:0] a);
    return (a == 7'd2) ? 8'hA7 : ({1'b0, a} ^ 8'h5A);
  endfunction

  // ---------------- behavioural I2C master ----------------
  logic       model_busy = 1'b0;
  logic       hold_busy = 1'b0;
  logic       never_done = 1'b0;
  logic       newd_seen = 1'b0;
  int         model_cnt = 0;
  int         done_left = 0;
  logic [6:0] model_addr = '0;

  assign i2c_busy = model_busy | hold_busy;
  assign i2c_done = (done_left > 0);

  always @(posedge clk) begin
    newd_seen <= i2c_newd;
    if (done_left > 0) done_left <= done_left - 1;
    if (i2c_newd && !newd_seen && !model_busy) begin
      model_busy <= 1'b1;
      model_cnt  <= MODEL_LAT;
      model_addr <= i2c_addr;
    end else if (model_busy && !never_done) begin
      if (model_cnt <= 1) begin
        model_busy  <= 1'b0;
        done_left   <= 2;
        i2c_dout    <= model_dout(model_addr);
        i2c_ack_err <= (model_addr == 7'd4);
      end else begin
        model_cnt <= model_cnt - 1;
      end
    end
  end

  // ---------------- newd pulse monitor ----------------
  logic newd_prev = 1'b0;
  int   newd_width = 0;

  always @(negedge clk) begin
    if (i2c_newd && !newd_prev) begin
      cmd_t e;
      pulses++;
      newd_width = 1;
      newd_rise_cyc = cyc;
      if (iss_q.size() == 0) begin
        check("newd_unexpected", 32'(i2c_newd), 32'd0);
      end else begin
        e = iss_q.pop_front();
        check("issue_op", 32'(i2c_op), 32'(e.op));
        check("issue_addr", 32'(i2c_addr), 32'(e.addr));
        if (e.op == OP_WR) check("issue_din", 32'(i2c_din), 32'(e.data));
      end
    end else if (i2c_newd) begin
      newd_width++;
    end else if (newd_prev && !rst) begin
      check("newd_width", 32'(newd_width), 32'(NEWD_HOLD));
    end
    newd_prev = i2c_newd;
  end

  // ---------------- response scoreboard ----------------
  logic        prev_hold = 1'b0;
  logic [17:0] prev_head = '0;

  always @(negedge clk) begin
    if (!rst) begin
      if (prev_hold && rsp_valid)
        check("rsp_stable", 32'({rsp_op, rsp_addr, rsp_data, rsp_ack_err, rsp_timeout}), 32'(prev_head));
      if (rsp_valid && rsp_ready) begin
        rsp_t e;
        rsp_seen++;
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 32'(rsp_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          $display("rsp op=%0d addr=%0d data=%02h ack_err=%0d timeout=%0d", rsp_op, rsp_addr, rsp_data, rsp_ack_err, rsp_timeout);
          check("rsp_op", 32'(rsp_op), 32'(e.op));
          check("rsp_addr", 32'(rsp_addr), 32'(e.addr));
          check("rsp_data", 32'(rsp_data), 32'(e.data));
          check("rsp_ack_err", 32'(rsp_ack_err), 32'(e.ack_err));
          check("rsp_timeout", 32'(rsp_timeout), 32'(e.timeout));
        end
      end
    end
    prev_hold = rsp_valid && !rsp_ready;
    prev_head = {rsp_op, rsp_addr, rsp_data, rsp_ack_err, rsp_timeout};
  end

  // ---------------- stimulus helpers ----------------
  // Called at a negedge; returns at the negedge after the command is accepted
  task automatic send_cmd(input logic op, input logic [6:0] a, input logic [7:0] d, input logic exp_to);
    int n;
    cmd_t c;
    rsp_t e;
    n = 0;
    cmd_op = op; cmd_addr = a; cmd_data = d; cmd_valid = 1'b1;
    while (!cmd_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      check("cmd_accept_wait", 32'(cmd_ready), 32'd1);
    end else begin
      c.op = op; c.addr = a; c.data = d;
      iss_q.push_back(c);
      e.op = op;
      e.addr = a;
      e.data = exp_to ? 8'h00 : ((op == OP_RD) ? model_dout(a) : d);
      e.ack_err = exp_to ? 1'b1 : (a == 7'd4);
      e.timeout = exp_to;
      exp_q.push_back(e);
      $display("cmd op=%0d addr=%0d data=%02h", op, a, d);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic set_rsp_ready(input logic v);
    @(posedge clk);
    #1 rsp_ready = v;
    @(negedge clk);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && idle && !rsp_valid) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int base;
    int n;
    int seen0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_idle", 32'(idle), 32'd1);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_newd", 32'(i2c_newd), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_cmd_count", 32'(cmd_count), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(cmd_ready), 32'd1);

    // Single write
    send_cmd(OP_WR, 7'd3, 8'h05, 1'b0);
    check("wr_cmd_count", 32'(cmd_count), 32'd1);
    check("wr_not_idle", 32'(idle), 32'd0);
    wait_drain("wr_drain", 2000);

    // Single read
    send_cmd(OP_RD, 7'd2, 8'h00, 1'b0);
    wait_drain("rd_drain", 2000);

    // NACK then a normal command
    send_cmd(OP_WR, 7'd4, 8'h11, 1'b0);
    send_cmd(OP_RD, 7'd1, 8'h00, 1'b0);
    wait_drain("nack_drain", 3000);

    // Burst with consumer stalled; master held busy so the queue fills first
    hold_busy = 1'b1;
    set_rsp_ready(1'b0);
    base = pulses;
    for (int i = 0; i < 4; i++) send_cmd(OP_WR, 7'(8 + i), 8'(8'h20 + i), 1'b0);
    check("burst_ready_low", 32'(cmd_ready), 32'd0);
    check("burst_count4", 32'(cmd_count), 32'd4);
    hold_busy = 1'b0;
    for (int i = 4; i < 6; i++) send_cmd(OP_RD, 7'(8 + i), 8'h00, 1'b0);
    repeat (1500) @(negedge clk);
    check("burst_pulses_stalled", 32'(pulses - base), 32'd4);
    check("burst_cmd_left", 32'(cmd_count), 32'd2);
    check("burst_rsp_valid", 32'(rsp_valid), 32'd1);
    set_rsp_ready(1'b1);
    wait_drain("burst_drain", 4000);
    check("burst_pulses_total", 32'(pulses - base), 32'd6);

    // Reset while waiting for done: in-flight command is abandoned
    send_cmd(OP_WR, 7'd5, 8'h09, 1'b0);
    n = 0;
    while (!i2c_newd && n < 1000) begin @(negedge clk); n++; end
    while (i2c_newd && n < 1000) begin @(negedge clk); n++; end
    check("rst_mid_reach_wait", 32'(n < 1000), 32'd1);
    repeat (20) @(negedge clk);
    seen0 = rsp_seen;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("rst_mid_newd", 32'(i2c_newd), 32'd0);
    check("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_mid_idle", 32'(idle), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (400) @(negedge clk);
    check("rst_mid_no_rsp", 32'(rsp_seen - seen0), 32'd0);
    check("rst_mid_rsp_valid_after", 32'(rsp_valid), 32'd0);

    // Recovery after reset
    send_cmd(OP_WR, 7'd6, 8'h3C, 1'b0);
    wait_drain("recover_drain", 2000);

`ifdef I2C_SEQ_TIMEOUT_EN
    // Watchdog: master never completes
    never_done = 1'b1;
    send_cmd(OP_RD, 7'd7, 8'h00, 1'b1);
    n = 0;
    while (!rsp_valid && n < 1000) begin @(negedge clk); n++; end
    // Watchdog moves to RESP 50 cycles after issue; the entry appears one cycle later
    check("timeout_latency", 32'(cyc - newd_rise_cyc), 32'(TO_CYCLES + 1));
    wait_drain("timeout_drain", 200);
`endif

    repeat (5) @(negedge clk);
    check("end_queue_empty", 32'(iss_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
